// File: rtl/aes256_round_sequencer.sv
// ---------------------------------------------------------------------------
// aes256_round_sequencer
//
// Control sequencer for the iterative AES-256 encryption datapath. After a
// start request it walks the datapath through the initial AddRoundKey and the
// 14 cipher rounds, one step per clock. It then pulses done for one cycle,
// while the cipher-text register holds the result.
//
// Optional feature: define AES_SEQ_ABORT_EN to add the abort input. A running
// encryption can then be cancelled without a done pulse.
//
// Ports:
//   clk             rising-edge clock
//   rst             synchronous, active-low reset
//   abort           (AES_SEQ_ABORT_EN only) cancel a running encryption
//   start           encryption request, accepted only while not busy
//   seldata         0 = registered plaintext, 1 = round feedback
//   selmixcol       1 = MixColumns feedback, 0 = ShiftRows (final round)
//   selkeyschedule  00/01 = external key upper/lower, 10/11 = feedback upper/lower
//   selmsb          key-schedule upper half source: 0 = external key, 1 = feedback
//   sellsb          key-schedule lower half source: 0 = external key, 1 = feedback
//   roundcount      rcon index for the key schedule (0..7)
//   busy            high during steps 0..14
//   done            one-cycle pulse, cipher text valid
// ---------------------------------------------------------------------------
module aes256_round_sequencer #(
  parameter int NSTEPS = 15
) (
  input  logic       clk,
  input  logic       rst,
`ifdef AES_SEQ_ABORT_EN
  input  logic       abort,
`endif
  input  logic       start,
  output logic       seldata,
  output logic       selmixcol,
  output logic [1:0] selkeyschedule,
  output logic       selmsb,
  output logic       sellsb,
  output logic [3:0] roundcount,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [3:0] LAST_STEP = 4'(NSTEPS - 1);

  state_t     state, state_nxt;
  logic [3:0] step, step_nxt;
  logic       abort_req;

`ifdef AES_SEQ_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // ---- state register ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      step  <= '0;
    end else begin
      state <= state_nxt;
      step  <= step_nxt;
    end
  end

  // ---- next state ----
  // DONE accepts start directly, so held-high start gives one block per
  // 16 cycles with no idle gap.
  always_comb begin
    state_nxt = state;
    step_nxt  = step;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          step_nxt  = '0;
        end
      end
      RUN: begin
        if (abort_req) begin
          state_nxt = IDLE;
          step_nxt  = '0;
        end else if (step == LAST_STEP) begin
          state_nxt = DONE;
          step_nxt  = '0;
        end else begin
          step_nxt = step + 4'd1;
        end
      end
      DONE: begin
        step_nxt = '0;
        if (start) state_nxt = RUN;
        else       state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        step_nxt  = '0;
      end
    endcase
  end

  // ---- output decode ----
  // Steps 0 and 1 load the two external key halves. From step 2 on, the
  // schedule feeds back and alternates upper/lower halves on step parity.
  always_comb begin
    seldata        = 1'b0;
    selmixcol      = 1'b0;
    selkeyschedule = 2'b00;
    selmsb         = 1'b0;
    sellsb         = 1'b0;
    roundcount     = 4'd0;
    if (state == RUN) begin
      seldata        = (step != 4'd0);
      selmixcol      = (step != LAST_STEP);
      selkeyschedule = {(step >= 4'd2), step[0]};
      selmsb         = (step >= 4'd2);
      sellsb         = (step >= 4'd2);
      roundcount     = {1'b0, step[3:1]};
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_aes256_round_sequencer.sv
// ---------------------------------------------------------------------------
// Testbench for aes256_round_sequencer.
//
// The reference model only remembers the cycle at which the current block was
// accepted. The expected outputs follow from the elapsed cycle count: steps
// 0..14 are running, 15 is the done cycle. Compile with AES_SEQ_ABORT_EN
// defined to exercise the abort input.
// ---------------------------------------------------------------------------
module tb_aes256_round_sequencer;

`ifdef AES_SEQ_ABORT_EN
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       abort;
  logic       start;
  logic       seldata, selmixcol, selmsb, sellsb, busy, done;
  logic [1:0] selkeyschedule;
  logic [3:0] roundcount;

  aes256_round_sequencer dut (
    .clk            (clk),
    .rst            (rst),
`ifdef AES_SEQ_ABORT_EN
    .abort          (abort),
`endif
    .start          (start),
    .seldata        (seldata),
    .selmixcol      (selmixcol),
    .selkeyschedule (selkeyschedule),
    .selmsb         (selmsb),
    .sellsb         (sellsb),
    .roundcount     (roundcount),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int failed = 0;

  // Reference model: the cycle index and the cycle at which the block was accepted.
  int cyc = 0;
  int t0  = 0;
  bit active = 1'b0;
  int done_seen = 0;

  function automatic int cur_step();
    return active ? (cyc - t0) : -1;
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_outputs();
    int k;
    bit run;
    k   = cur_step();
    run = active && (k >= 0) && (k <= 14);
    chk("seldata",        {3'b0, seldata},        {3'b0, run && (k != 0)});
    chk("selmixcol",      {3'b0, selmixcol},      {3'b0, run && (k != 14)});
    chk("selkeyschedule", {2'b0, selkeyschedule},
        !run ? 4'd0 : (k == 0) ? 4'd0 : (k == 1) ? 4'd1 : ((k % 2) == 0) ? 4'd2 : 4'd3);
    chk("selmsb",         {3'b0, selmsb},         {3'b0, run && (k >= 2)});
    chk("sellsb",         {3'b0, sellsb},         {3'b0, run && (k >= 2)});
    chk("roundcount",     roundcount,             run ? 4'(k / 2) : 4'd0);
    chk("busy",           {3'b0, busy},           {3'b0, run});
    chk("done",           {3'b0, done},           {3'b0, active && (k == 15)});
    if (done === 1'b1) done_seen++;
  endtask

  task automatic model_edge();
    int k;
    k = cur_step();
    cyc++;
    if (!rst)                                 active = 1'b0;
    else if (active && k >= 0 && k <= 14) begin
      if (ABORT_EN && abort)                  active = 1'b0;
    end
    else if (start) begin
      active = 1'b1;
      t0     = cyc;
    end
    else                                      active = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int d0;
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    @(posedge clk);
    model_edge();
    #1;

    // Reset held: all outputs at reset values.
    ticks(3);
    rst = 1'b1;
    ticks(2);

    // Single start pulse: full 15-step run, then done, then idle.
    d0 = done_seen;
    start = 1'b1; tick(); start = 1'b0;
    ticks(20);
    chk("done_count_single", 4'(done_seen - d0), 4'd1);

    // Start pulse at s=5 is ignored and not queued.
    d0 = done_seen;
    start = 1'b1; tick(); start = 1'b0;
    ticks(5);
    start = 1'b1; tick(); start = 1'b0;
    ticks(30);
    chk("done_count_ignored", 4'(done_seen - d0), 4'd1);

    // Start held high: back-to-back blocks every 16 cycles.
    d0 = done_seen;
    start = 1'b1; ticks(48); start = 1'b0;
    ticks(20);
    chk("done_count_held", 4'(done_seen - d0), 4'd3);

    // Reset at s=7 kills the run; a fresh start then completes.
    d0 = done_seen;
    start = 1'b1; tick(); start = 1'b0;
    ticks(7);
    rst = 1'b0; tick(); rst = 1'b1;
    ticks(3);
    chk("done_count_reset", 4'(done_seen - d0), 4'd0);
    start = 1'b1; tick(); start = 1'b0;
    ticks(18);

    if (ABORT_EN) begin
      // Abort at s=3: no done.
      d0 = done_seen;
      start = 1'b1; tick(); start = 1'b0;
      ticks(3);
      abort = 1'b1; tick(); abort = 1'b0;
      ticks(20);
      chk("done_count_abort", 4'(done_seen - d0), 4'd0);
      // Abort and start together in DONE: start wins.
      start = 1'b1; tick(); start = 1'b0;
      ticks(15);
      abort = 1'b1; start = 1'b1; tick(); abort = 1'b0; start = 1'b0;
      ticks(20);
    end

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      start = ($urandom_range(3) == 0);
      rst   = ($urandom_range(80) != 0);
      abort = ABORT_EN && ($urandom_range(20) == 0);
      tick();
    end
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    ticks(20);

    $display("%0d/%0d checks passed", passed, passed + failed);
    $finish;
  end

endmodule
